// File: rtl/onp_arbiter_if.sv
// Bundle of requester, result and converter-side signals shared by the arbiter.
// slave is the arbiter's view; master is the environment driving it.
interface onp_arbiter_if;
  logic       s0_valid;
  logic [3:0] s0_data;
  logic       s0_ready;
  logic       s1_valid;
  logic [3:0] s1_data;
  logic       s1_ready;
  logic       o0_valid;
  logic [3:0] o0_data;
  logic       o0_ack;
  logic       o1_valid;
  logic [3:0] o1_data;
  logic       o1_ack;
  logic       err0;
  logic       err1;
  logic       busy;
  logic       owner;
  logic [3:0] conv_in_data;
  logic       conv_wr_data;
  logic       conv_ready;
  logic [3:0] conv_data;
  logic       conv_rd;

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, o0_ack, o1_ack, conv_ready, conv_data,
    output s0_ready, s1_ready, o0_valid, o0_data, o1_valid, o1_data,
           err0, err1, busy, owner, conv_in_data, conv_wr_data, conv_rd
  );

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, o0_ack, o1_ack, conv_ready, conv_data,
    input  s0_ready, s1_ready, o0_valid, o0_data, o1_valid, o1_data,
           err0, err1, busy, owner, conv_in_data, conv_wr_data, conv_rd
  );
endinterface

// File: rtl/onp_arbiter.sv
// Round-robin sharing of one infix-to-RPN converter between two requesters,
// one whole expression ('=' terminated) at a time, with overlength truncation.
module onp_arbiter #(
  parameter int MAX_LEN = 15
) (
  input  logic          clk,
  input  logic          rst,
  onp_arbiter_if.slave  bus
);

  localparam logic [3:0] TOK_EQ   = 4'hD;
  localparam logic [4:0] LAST_TOK = 5'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, FEED, INJECT, DRAIN} state_t;

  state_t          r_state, w_state_next;
  logic            r_owner, w_owner_next;
  logic [4:0]      r_len, w_len_next;
  logic [3:0]      r_conv_in_data, w_conv_in_data_next;
  logic            r_conv_wr, w_conv_wr_next;
  logic            r_conv_rd, w_conv_rd_next;
  logic [1:0]      r_err, w_err_next;
  logic [1:0]      r_ov, w_ov_next;
  logic [1:0][3:0] r_od, w_od_next;

  logic [1:0] w_sv;
  logic [1:0] w_ack;
  logic [1:0] w_ready;
  logic       w_own_valid;
  logic [3:0] w_own_data;
  logic       w_accept;
  logic       w_route;

  assign w_sv        = {bus.s1_valid, bus.s0_valid};
  assign w_ack       = {bus.o1_ack, bus.o0_ack};
  assign w_own_valid = w_sv[r_owner];
  assign w_own_data  = r_owner ? bus.s1_data : bus.s0_data;
  assign w_ready[0]  = (r_state == FEED) && !r_owner;
  assign w_ready[1]  = (r_state == FEED) && r_owner;
  assign w_accept    = (r_state == FEED) && w_own_valid;

  // A read is skipped right after one, since the FIFO head is still the old token.
  assign w_route = (r_state != IDLE) && bus.conv_ready && !r_conv_rd &&
                   (!r_ov[r_owner] || w_ack[r_owner]);

  always_comb begin
    w_state_next        = r_state;
    w_owner_next        = r_owner;
    w_len_next          = r_len;
    w_conv_in_data_next = r_conv_in_data;
    w_conv_wr_next      = 1'b0;
    w_conv_rd_next      = w_route;
    w_err_next          = 2'b00;
    w_ov_next           = r_ov & ~w_ack;
    w_od_next           = r_od;

    if (w_route) begin
      w_ov_next[r_owner] = 1'b1;
      w_od_next[r_owner] = bus.conv_data;
    end

    case (r_state)
      IDLE: begin
        if (|w_sv) begin
          w_owner_next = (&w_sv) ? ~r_owner : w_sv[1];
          w_len_next   = 5'd0;
          w_state_next = FEED;
        end
      end
      FEED: begin
        if (w_accept) begin
          w_conv_in_data_next = w_own_data;
          w_conv_wr_next      = 1'b1;
          w_len_next          = r_len + 5'd1;
          if (w_own_data == TOK_EQ) begin
            w_state_next = DRAIN;
          end else if (w_len_next == LAST_TOK) begin
            w_state_next = INJECT;
          end
        end
      end
      INJECT: begin
        w_conv_in_data_next = TOK_EQ;
        w_conv_wr_next      = 1'b1;
        w_err_next[r_owner] = 1'b1;
        w_state_next        = DRAIN;
      end
      DRAIN: begin
        w_state_next = DRAIN;
      end
      default: w_state_next = IDLE;
    endcase

    // The expression ends when its '=' leaves the converter.
    if (w_route && (bus.conv_data == TOK_EQ)) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_owner        <= 1'b1;
      r_len          <= 5'd0;
      r_conv_in_data <= 4'd0;
      r_conv_wr      <= 1'b0;
      r_conv_rd      <= 1'b0;
      r_err          <= 2'b00;
      r_ov           <= 2'b00;
      r_od           <= '0;
    end else begin
      r_state        <= w_state_next;
      r_owner        <= w_owner_next;
      r_len          <= w_len_next;
      r_conv_in_data <= w_conv_in_data_next;
      r_conv_wr      <= w_conv_wr_next;
      r_conv_rd      <= w_conv_rd_next;
      r_err          <= w_err_next;
      r_ov           <= w_ov_next;
      r_od           <= w_od_next;
    end
  end

  assign bus.s0_ready     = w_ready[0];
  assign bus.s1_ready     = w_ready[1];
  assign bus.o0_valid     = r_ov[0];
  assign bus.o0_data      = r_od[0];
  assign bus.o1_valid     = r_ov[1];
  assign bus.o1_data      = r_od[1];
  assign bus.err0         = r_err[0];
  assign bus.err1         = r_err[1];
  assign bus.busy         = (r_state != IDLE);
  assign bus.owner        = r_owner;
  assign bus.conv_in_data = r_conv_in_data;
  assign bus.conv_wr_data = r_conv_wr;
  assign bus.conv_rd      = r_conv_rd;

endmodule
